// File: rtl/one_max_ga_core.sv
// one_max_ga_core
//   OneMax genetic-algorithm engine. Evolves POP_SIZE chromosomes of CHROM_W
//   bits toward all-ones using elitism, 2-way tournament selection,
//   single-point crossover and single-bit mutation, all driven by a 32-bit
//   Galois LFSR that advances only while the engine is busy.
//
// Ports
//   CLOCK_50     : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : level; sampled in IDLE or DONE
//   mode         : init mode (0 random, 1 all-zeros, 2 all-ones, 3 = random)
//   mut_thresh   : mutation probability numerator (/256)
//   busy         : high in every state except IDLE and DONE
//   done         : high in DONE
//   found        : an all-ones chromosome was reached (valid while done)
//   best_fitness : popcount of best_chrom
//   best_chrom   : best chromosome of the last evaluated generation
//   generation   : index of the last evaluated generation
module one_max_ga_core #(
    parameter int          CHROM_W  = 16,
    parameter int          POP_SIZE = 8,
    parameter int          MAX_GEN  = 255,
    parameter logic [31:0] SEED     = 32'hACE1_2025
) (
    input  logic                         CLOCK_50,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [7:0]                   mut_thresh,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [$clog2(CHROM_W+1)-1:0] best_fitness,
    output logic [CHROM_W-1:0]           best_chrom,
    output logic [15:0]                  generation
);

    localparam int          P         = POP_SIZE;
    localparam int          L         = $clog2(POP_SIZE);
    localparam int          C         = $clog2(CHROM_W);
    localparam int          FIT_W     = $clog2(CHROM_W + 1);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_EVAL, S_CHECK, S_ELITE,
        S_SEL_A, S_SEL_B, S_XMUT, S_COPY, S_DONE
    } state_t;

    state_t               state;
    logic [31:0]          lfsr;
    logic [L-1:0]         idx;
    logic [1:0]           mode_q;
    logic [7:0]           mut_q;
    logic [CHROM_W-1:0]   pop [P];
    logic [CHROM_W-1:0]   nxt [P];
    logic [FIT_W-1:0]     fit [P];
    logic [FIT_W-1:0]     run_fit;
    logic [CHROM_W-1:0]   run_chrom;
    logic [CHROM_W-1:0]   par_a;
    logic [CHROM_W-1:0]   par_b;

    function automatic logic [FIT_W-1:0] popcount(input logic [CHROM_W-1:0] v);
        logic [FIT_W-1:0] n;
        n = '0;
        for (int b = 0; b < CHROM_W; b++) n = n + FIT_W'(v[b]);
        return n;
    endfunction

    // Bits [c-1:0] set; c = 0 yields an empty mask.
    function automatic logic [CHROM_W-1:0] lowmask(input logic [C-1:0] c);
        return (CHROM_W'(1) << c) - CHROM_W'(1);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'd0);
    endfunction

    logic [FIT_W-1:0]   cur_fit;
    logic               cur_better;
    logic               idx_last;
    logic [L-1:0]       sel_i;
    logic [L-1:0]       sel_j;
    logic [CHROM_W-1:0] tour_win;
    logic [C-1:0]       cut;
    logic [C-1:0]       flip_pos;
    logic [CHROM_W-1:0] child_x;
    logic [CHROM_W-1:0] child;
    logic [CHROM_W-1:0] init_val;

    assign cur_fit    = popcount(pop[idx]);
    // Index 0 always seeds the running best; afterwards only strictly
    // greater fitness replaces it, so ties keep the lower index.
    assign cur_better = (idx == '0) || (cur_fit > run_fit);
    assign idx_last   = (idx == L'(P - 1));
    assign sel_i      = lfsr[L-1:0];
    assign sel_j      = lfsr[2*L-1:L];
    assign tour_win   = (fit[sel_i] >= fit[sel_j]) ? pop[sel_i] : pop[sel_j];
    assign cut        = lfsr[C-1:0];
    assign flip_pos   = lfsr[20 +: C];
    assign child_x    = (par_a & lowmask(cut)) | (par_b & ~lowmask(cut));
    assign child      = (lfsr[15:8] < mut_q) ? (child_x ^ (CHROM_W'(1) << flip_pos))
                                             : child_x;

    always_comb begin
        init_val = lfsr[CHROM_W-1:0];
        case (mode_q)
            2'd1:    init_val = '0;
            2'd2:    init_val = '1;
            default: init_val = lfsr[CHROM_W-1:0];
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_INIT;
            idx          <= '0;
            mode_q       <= '0;
            mut_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            best_fitness <= '0;
            best_chrom   <= '0;
            generation   <= '0;
            run_fit      <= '0;
            run_chrom    <= '0;
            par_a        <= '0;
            par_b        <= '0;
            for (int k = 0; k < P; k++) begin
                pop[k] <= '0;
                nxt[k] <= '0;
                fit[k] <= '0;
            end
        end else begin
            if (state != S_IDLE && state != S_DONE) lfsr <= lfsr_step(lfsr);

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q       <= mode;
                        mut_q        <= mut_thresh;
                        generation   <= '0;
                        found        <= 1'b0;
                        best_fitness <= '0;
                        best_chrom   <= '0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        idx          <= '0;
                        state        <= S_INIT;
                    end
                end
                S_INIT: begin
                    pop[idx] <= init_val;
                    idx      <= idx + L'(1);
                    if (idx_last) state <= S_EVAL;
                end
                S_EVAL: begin
                    fit[idx] <= cur_fit;
                    if (cur_better) begin
                        run_fit   <= cur_fit;
                        run_chrom <= pop[idx];
                    end
                    idx <= idx + L'(1);
                    if (idx_last) begin
                        best_fitness <= cur_better ? cur_fit : run_fit;
                        best_chrom   <= cur_better ? pop[idx] : run_chrom;
                        state        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (best_fitness == FIT_W'(CHROM_W)) begin
                        found <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (generation == 16'(MAX_GEN)) begin
                        found <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_ELITE;
                    end
                end
                S_ELITE: begin
                    nxt[0] <= best_chrom;
                    idx    <= L'(1);
                    state  <= S_SEL_A;
                end
                S_SEL_A: begin
                    par_a <= tour_win;
                    state <= S_SEL_B;
                end
                S_SEL_B: begin
                    par_b <= tour_win;
                    state <= S_XMUT;
                end
                S_XMUT: begin
                    nxt[idx] <= child;
                    idx      <= idx + L'(1);
                    state    <= idx_last ? S_COPY : S_SEL_A;
                end
                S_COPY: begin
                    for (int k = 0; k < P; k++) pop[k] <= nxt[k];
                    generation <= generation + 16'd1;
                    state      <= S_EVAL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/one_max_ga_core.md
# one_max_ga_core

Parametrised OneMax genetic-algorithm engine. It evolves a population of POP_SIZE chromosomes, each CHROM_W bits wide, toward all-ones. Each generation uses elitism, 2-way tournament selection, single-point crossover and single-bit mutation, all driven by an internal 32-bit LFSR. It sits behind the board top level: switches supply start, mode and mutation rate, and the outputs feed the HEX/LED display logic.

## Interface
- CHROM_W, 16: chromosome width; power of two, 4..32
- POP_SIZE, 8: population size; power of two, 4..64
- MAX_GEN, 255: last generation index evaluated before giving up, 1..65535
- SEED, 32'hACE1_2025: LFSR reset value; 0 is replaced by 1
- CLOCK_50  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE or DONE
- mode  in  2  init mode, sampled with start: 0 random, 1 all-zeros, 2 all-ones, 3 treated as 0
- mut_thresh  in  8  mutation probability numerator (/256), sampled with start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- found  out  1  an all-ones chromosome was reached; valid while done
- best_fitness  out  $clog2(CHROM_W+1)  popcount of best_chrom
- best_chrom  out  CHROM_W  best chromosome of the last evaluated generation
- generation  out  16  index of the last evaluated generation

## Operation
- Storage: pop[POP_SIZE], nxt[POP_SIZE], fit[POP_SIZE] registers. P = POP_SIZE, L = $clog2(P), C = $clog2(CHROM_W).
- LFSR: 32-bit Galois, mask 32'h8020_0003, shift right. It advances every cycle while busy and holds in IDLE and DONE.
- FSM: IDLE, INIT, EVAL, CHECK, ELITE, SEL_A, SEL_B, XMUT, COPY, DONE.
- IDLE/DONE: if start=1, latch mode and mut_thresh, clear generation/found/best, clear done, go to INIT.
- INIT: P cycles; pop[k] is set to lfsr[CHROM_W-1:0], all-zeros or all-ones according to mode.
- EVAL: P cycles; fit[k] = popcount(pop[k]). The best is replaced only on strictly greater fitness, so ties keep the lower index. best_chrom and best_fitness update at EVAL end.
- CHECK: 1 cycle.
  - If best_fitness == CHROM_W: found=1, go to DONE.
  - Else if generation == MAX_GEN: found=0, go to DONE.
  - Else go to ELITE.
- ELITE: nxt[0] = best_chrom.
- Children k = 1..P-1, 3 cycles each:
  - SEL_A: i = lfsr[L-1:0], j = lfsr[2L-1:L]; parent A = higher fit; tie selects i.
  - SEL_B: same rule gives parent B.
  - XMUT: c = lfsr[C-1:0]; child = (A & lowmask(c)) | (B & ~lowmask(c)), where lowmask(c) has bits [c-1:0] set, so c=0 gives child = B. If lfsr[15:8] < mut_thresh, flip bit lfsr[20+:C]. Write nxt[k].
- COPY: pop = nxt, generation += 1, go to EVAL.
- mut_thresh=0 never mutates. The elite guarantees best_fitness never decreases across generations.
- start while busy is ignored. start held high in DONE restarts immediately.

## Timing
- Reset values:
  - state IDLE; busy, done, found = 0
  - best_fitness = 0, best_chrom = 0, generation = 0
  - lfsr = SEED; pop, nxt, fit = 0
- Reset mid-run aborts to IDLE immediately, asynchronously.
- The edge that samples start enters INIT. INIT takes P edges, EVAL takes P, CHECK takes 1.
- First CHECK completes 2P+1 edges after the start edge.
- Each further generation costs 4P edges: ELITE 1, children 3(P-1), COPY 1, EVAL P, CHECK 1.
- Found at generation g: done rises 2P+1+4P·g edges after the start edge.
- Outputs are registered and change only on clock edges. best_* are stable between EVAL ends.

## Test plan
- Reset: rst_n=0 mid-INIT, asynchronously, without a clock -> busy=0, done=0, generation=0, best_fitness=0; after release, idle until start.
- All-ones: P=8, mode=2, pulse start -> done=1 and found=1 exactly 17 edges after start; generation=0; best_fitness=CHROM_W; best_chrom all-ones.
- All-zeros, no mutation: P=8, MAX_GEN=4, mode=1, mut_thresh=0 -> done at edge 145; found=0; generation=4; best_fitness=0.
- Elitism: mode=0, mut_thresh=0, MAX_GEN=50 -> best_fitness sampled at each CHECK never decreases; busy=1 throughout.
- Convergence: CHROM_W=8, P=16, mode=0, mut_thresh=32 -> found=1 before generation 255; best_chrom=8'hFF.
- Restart and ignore: start pulsed while busy changes nothing; start in DONE with mode=2 -> done drops the next edge and rises again 2P+1 edges after it; a reference model of the LFSR matches the sampled INIT contents.
